// File: rtl/md_unit_if.sv
// md_unit_if: E-stage multiply/divide request and HI/LO result bundle.
// The pipeline side drives the request through the master modport.
// md_unit receives it through the slave modport.
interface md_unit_if;
    logic        respon;
    logic        E_valid;
    logic        start;
    logic [1:0]  MDop;
    logic        MDsign;
    logic        mt_we;
    logic        HIWrite;
    logic        HIRead;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hl_out;

    modport master (
        output respon, E_valid, start, MDop, MDsign, mt_we, HIWrite, HIRead, srcA, srcB,
        input  busy, hi, lo, hl_out
    );

    modport slave (
        input  respon, E_valid, start, MDop, MDsign, mt_we, HIWrite, HIRead, srcA, srcB,
        output busy, hi, lo, hl_out
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit that owns the HI/LO registers.
// The result is computed when the op is accepted and held in tHI/tLO.
// It is committed to HI/LO after a fixed latency, while busy is high.
// Optional feature macro MD_MADD_EN enables MADD (MDop 10) and MSUB (MDop 11),
// which accumulate into HI/LO.
// Without MD_MADD_EN, MDop[1] is ignored.
module md_unit #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;

    typedef enum logic {IDLE, BUSY} stateT;

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    hiReg, loReg;
    logic [DW-1:0]    tHI, tLO;

    logic             accept, mtAccept, isDiv;
    logic             aNeg, bNeg, divZero;
    logic [DW-1:0]    aMag, bMag, bDiv, quo, rem;
    logic [2*DW-1:0]  aExt, bExt, prod, result;

    // Acceptance is gated by idle state and the exception response; start wins over mt_we
    always_comb begin
        accept   = md.E_valid && md.start && !md.respon && (state == IDLE);
        mtAccept = md.E_valid && md.mt_we && !md.start && !md.respon && (state == IDLE);
    end

    // Result datapath: one shared multiplier and a sign-magnitude divider
    always_comb begin
        result  = {hiReg, loReg};
`ifdef MD_MADD_EN
        isDiv   = (md.MDop == 2'b01);
`else
        isDiv   = md.MDop[0];
`endif
        aNeg    = md.MDsign && md.srcA[DW-1];
        bNeg    = md.MDsign && md.srcB[DW-1];
        aMag    = aNeg ? -md.srcA : md.srcA;
        bMag    = bNeg ? -md.srcB : md.srcB;
        divZero = (md.srcB == '0);
        bDiv    = divZero ? DW'(1) : bMag;
        quo     = aMag / bDiv;
        rem     = aMag % bDiv;
        // Sign-extending into 64 bits makes the low 64 product bits correct for both signednesses
        aExt    = {{DW{aNeg}}, md.srcA};
        bExt    = {{DW{bNeg}}, md.srcB};
        prod    = aExt * bExt;
        if (isDiv) begin
            // Divide by zero keeps the current HI/LO, which cannot change while busy
            if (!divZero)
                result = {(aNeg ? -rem : rem), ((aNeg ^ bNeg) ? -quo : quo)};
        end else begin
`ifdef MD_MADD_EN
            case (md.MDop)
                2'b10:   result = {hiReg, loReg} + prod;
                2'b11:   result = {hiReg, loReg} - prod;
                default: result = prod;
            endcase
`else
            result = prod;
`endif
        end
    end

`ifndef MD_MADD_EN
    logic unusedMdop;
    assign unusedMdop = md.MDop[1];
`endif

    // Control FSM, latency counter and HI/LO/temp registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            hiReg <= '0;
            loReg <= '0;
            tHI   <= '0;
            tLO   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tHI   <= result[2*DW-1:DW];
                        tLO   <= result[DW-1:0];
                        cnt   <= isDiv ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                        state <= BUSY;
                    end else if (mtAccept) begin
                        if (md.HIWrite)
                            hiReg <= md.srcA;
                        else
                            loReg <= md.srcA;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        hiReg <= tHI;
                        loReg <= tLO;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md.busy   = (state == BUSY);
    assign md.hi     = hiReg;
    assign md.lo     = loReg;
    assign md.hl_out = md.HIRead ? hiReg : loReg;
endmodule
